// File: rtl/uart_mem_sequencer.sv
// Single-port byte memory sequencer: UART bulk load, processor run, UART bulk dump.
// The memory port is owned by exactly one agent per phase; start/done frame one full pass.
module uart_mem_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int LOAD_LEN = 65536,
  parameter int DUMP_LEN = 65536
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              mem_read,
  output logic              mem_write,
  output logic              cpu_run,
  input  logic              cpu_done,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_write,
  input  logic              cpu_read,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W:0]   count,
  output logic [2:0]        phase,
  output logic              done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_DUMP_RD   = 3'd3;
  localparam logic [2:0] S_DUMP_TX   = 3'd4;
  localparam logic [2:0] S_DUMP_WAIT = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [ADDR_W:0] LOAD_END = LOAD_LEN[ADDR_W:0];
  localparam logic [ADDR_W:0] DUMP_END = DUMP_LEN[ADDR_W:0];

  logic [2:0]        state;
  logic [ADDR_W:0]   cnt_inc;
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [7:0]        wr_data_p1;
  logic              seen_busy;
  logic [1:0]        wait_cnt;

  assign cnt_inc = count + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      count      <= '0;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      seen_busy  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      wr_vld_p1 <= 1'b0;
      tx_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            count <= '0;
          end
        end
        // ---- load stage p0 -> p1: strobe captured, write issued next cycle
        S_LOAD: begin
          if (rx_ready) begin
            wr_vld_p1  <= 1'b1;
            wr_addr_p1 <= count[ADDR_W-1:0];
            wr_data_p1 <= rx_data;
            count      <= cnt_inc;
            if (cnt_inc == LOAD_END) state <= S_RUN;
          end
        end
        // count shows the final load total for one cycle, then clears
        S_RUN: begin
          count <= '0;
          if (cpu_done) state <= S_DUMP_RD;
        end
        S_DUMP_RD: state <= S_DUMP_TX;
        S_DUMP_TX: begin
          if (!tx_busy) begin
            tx_data   <= mem_dout;
            tx_start  <= 1'b1;
            seen_busy <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_DUMP_WAIT;
          end
        end
        // a transmitter that never raises busy is released after two cycles
        S_DUMP_WAIT: begin
          if (tx_busy) seen_busy <= 1'b1;
          if (wait_cnt != 2'd3) wait_cnt <= wait_cnt + 2'd1;
          if (!tx_busy && (seen_busy || wait_cnt == 2'd2)) begin
            count <= cnt_inc;
            state <= (cnt_inc == DUMP_END) ? S_DONE : S_DUMP_RD;
          end
        end
        S_DONE: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The last load byte lands in the first RUN cycle; it takes the port for that cycle.
  always_comb begin
    mem_addr  = wr_addr_p1;
    mem_din   = wr_data_p1;
    mem_write = wr_vld_p1;
    mem_read  = 1'b0;
    if (state == S_RUN && !wr_vld_p1) begin
      mem_addr  = cpu_addr;
      mem_din   = cpu_din;
      mem_write = cpu_write;
      mem_read  = cpu_read;
    end else if (state == S_DUMP_RD) begin
      mem_addr = count[ADDR_W-1:0];
      mem_read = 1'b1;
    end
  end

  assign cpu_run   = (state == S_RUN);
  assign cpu_rdata = cpu_run ? mem_dout : 8'h00;
  assign done      = (state == S_DONE);
  assign phase     = state;

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Scoreboard bench: stimulus queues expected memory writes and transmit bytes,
// a negedge monitor pops and compares whenever the sequencer emits one.
module tb_uart_mem_sequencer;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, start, rx_ready, tx_busy, cpu_done, cpu_write, cpu_read;
  logic [7:0]  rx_data, cpu_din, mem_dout;
  logic [15:0] cpu_addr;
  logic        tx_start, mem_read, mem_write, cpu_run, done;
  logic [7:0]  tx_data, mem_din, cpu_rdata;
  logic [15:0] mem_addr;
  logic [16:0] count;
  logic [2:0]  phase;

  uart_mem_sequencer #(.ADDR_W(16), .LOAD_LEN(4), .DUMP_LEN(4)) dut (
    .clk(clk), .Reset(Reset), .start(start), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_read(mem_read), .mem_write(mem_write),
    .cpu_run(cpu_run), .cpu_done(cpu_done), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_rdata(cpu_rdata),
    .count(count), .phase(phase), .done(done)
  );

  // Small-address instance for the full-range load
  logic       start_b, rx_ready_b, zero1;
  logic [7:0] rx_data_b, zero8;
  logic [3:0] zero4;
  logic       tx_start_b, mem_read_b, mem_write_b, cpu_run_b, done_b;
  logic [7:0] tx_data_b, mem_din_b, cpu_rdata_b;
  logic [3:0] mem_addr_b;
  logic [4:0] count_b;
  logic [2:0] phase_b;

  uart_mem_sequencer #(.ADDR_W(4), .LOAD_LEN(16), .DUMP_LEN(16)) dut_b (
    .clk(clk), .Reset(Reset), .start(start_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
    .tx_busy(zero1), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_dout(zero8),
    .mem_read(mem_read_b), .mem_write(mem_write_b),
    .cpu_run(cpu_run_b), .cpu_done(zero1), .cpu_addr(zero4), .cpu_din(zero8),
    .cpu_write(zero1), .cpu_read(zero1), .cpu_rdata(cpu_rdata_b),
    .count(count_b), .phase(phase_b), .done(done_b)
  );

  // Registered-output memory and a transmitter busy for 10 cycles per byte
  logic [7:0] mem [0:65535];
  int         busy_cnt;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    if (mem_read)  mem_dout <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (Reset) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_wr[$];
  wr_t  exp_wr_b[$];
  logic [7:0] exp_tx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output with no expected entry", name);
  endtask

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_wr.size() == 0) unexpected("mem_write");
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.addr));
        chk("wr_data", 32'(mem_din), 32'(w.data));
      end
    end
    if (tx_start === 1'b1) begin
      chk("tx_start_when_idle", 32'(tx_busy), 32'd0);
      if (exp_tx.size() == 0) unexpected("tx_start");
      else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    if (mem_write_b === 1'b1) begin
      if (exp_wr_b.size() == 0) unexpected("mem_write_b");
      else begin
        wr_t w;
        w = exp_wr_b.pop_front();
        chk("wr_addr_b", 32'(mem_addr_b), 32'(w.addr));
        chk("wr_data_b", 32'(mem_din_b), 32'(w.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [31:0] bytes);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = bytes[31-8*i -: 8];
      rx_data  = d;
      rx_ready = 1'b1;
      exp_wr.push_back({16'(i), d});
      step();
      rx_ready = 1'b0;
      @(negedge clk);
      chk("load_count", 32'(count), 32'(i + 1));
      chk("load_phase", 32'(phase), (i == 3) ? 32'd2 : 32'd1);
      step();
    end
    @(negedge clk);
    chk("run_count_clear", 32'(count), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    cpu_done = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0; cpu_addr = 16'h0; cpu_din = 8'h00;
    start_b = 1'b0; rx_ready_b = 1'b0; rx_data_b = 8'h00;
    zero1 = 1'b0; zero4 = 4'h0; zero8 = 8'h00; mem_dout = 8'h00;
    repeat (3) step();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Core access outside RUN is blocked
    step();
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 16'd7; cpu_din = 8'hEE;
    @(negedge clk);
    chk("idle_cpu_write_blocked", 32'(mem_write), 32'd0);
    chk("idle_cpu_read_blocked", 32'(mem_read), 32'd0);
    chk("idle_cpu_rdata", 32'(cpu_rdata), 32'd0);
    step();
    cpu_write = 1'b0; cpu_read = 1'b0;

    load4(32'hA1B2C3D4);

    // Stray strobe in RUN
    rx_ready = 1'b1; rx_data = 8'hFF;
    @(negedge clk);
    chk("run_stray_rx", 32'(mem_write), 32'd0);
    step();
    rx_ready = 1'b0;

    // Core write/read through the mirrored port
    cpu_addr = 16'd2; cpu_din = 8'h5A; cpu_write = 1'b1;
    exp_wr.push_back({16'd2, 8'h5A});
    @(negedge clk);
    chk("run_cpu_run", 32'(cpu_run), 32'd1);
    step();
    cpu_write = 1'b0; cpu_read = 1'b1;
    @(negedge clk);
    chk("run_mem_read", 32'(mem_read), 32'd1);
    step();
    cpu_read = 1'b0;
    @(negedge clk);
    chk("run_cpu_rdata", 32'(cpu_rdata), 32'h5A);
    step();
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    rx_ready = 1'b1;
    start = 1'b1;
    exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'hD4);
    @(negedge clk);
    chk("dump_rd_phase", 32'(phase), 32'd3);
    chk("dump_cpu_run_low", 32'(cpu_run), 32'd0);
    chk("dump_rd_read", 32'(mem_read), 32'd1);
    chk("dump_rd_addr", 32'(mem_addr), 32'd0);
    chk("dump_stray_rx", 32'(mem_write), 32'd0);
    step();
    rx_ready = 1'b0;

    for (int i = 0; i < 300 && done !== 1'b1; i++) step();
    @(negedge clk);
    chk("dump_done", 32'(done), 32'd1);
    chk("done_phase", 32'(phase), 32'd6);
    chk("done_count", 32'(count), 32'd4);
    chk("tx_bytes_left", 32'(exp_tx.size()), 32'd0);
    repeat (3) step();
    @(negedge clk);
    chk("done_held_by_start", 32'(phase), 32'd6);
    start = 1'b0;
    step();
    @(negedge clk);
    chk("done_to_idle", 32'(phase), 32'd0);
    chk("idle_done_low", 32'(done), 32'd0);

    // Reset after two load bytes
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_data = (i == 0) ? 8'h11 : 8'h22;
      rx_ready = 1'b1;
      exp_wr.push_back({16'(i), rx_data});
      step();
      rx_ready = 1'b0;
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_load_phase", 32'(phase), 32'd0);
    chk("rst_load_count", 32'(count), 32'd0);
    chk("rst_load_mem_write", 32'(mem_write), 32'd0);
    chk("rst_load_tx_start", 32'(tx_start), 32'd0);
    step();
    load4(32'h11223344);

    // Reset while waiting on the transmitter
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    exp_tx.push_back(8'h11);
    for (int i = 0; i < 50 && phase !== 3'd5; i++) step();
    chk("reach_dump_wait", 32'(phase), 32'd5);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_dump_phase", 32'(phase), 32'd0);
    chk("rst_dump_count", 32'(count), 32'd0);
    chk("rst_dump_tx_start", 32'(tx_start), 32'd0);
    chk("rst_dump_mem_write", 32'(mem_write), 32'd0);
    chk("rst_dump_tx_data", 32'(tx_data), 32'd0);
    step();
    load4(32'h55667788);

    // Full 16-byte load on the 4-bit address instance, strobes back to back
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    rx_ready_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data_b = 8'h30 + 8'(i);
      exp_wr_b.push_back({16'(i), rx_data_b});
      step();
    end
    @(negedge clk);
    chk("max_phase_run", 32'(phase_b), 32'd2);
    chk("max_count_16", 32'(count_b), 32'd16);
    step();
    rx_ready_b = 1'b0;
    @(negedge clk);
    chk("max_count_clear", 32'(count_b), 32'd0);

    repeat (2) step();
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("wr_b_left", 32'(exp_wr_b.size()), 32'd0);
    chk("tx_left", 32'(exp_tx.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_mem_sequencer.md
Name: uart_mem_sequencer

Overview:
- Top-level controller for the shared byte memory.
- Sequences three phases over one memory port: UART bulk load (receiver → memory), processor run (core owns memory), UART bulk dump (memory → transmitter).
- Arbitrates the single memory port between the UART path and the processor core by phase, never concurrently.
- Replaces free-running load/dump logic with an explicit start/done handshake and a bounded, parameterised byte count.

Parameters:
- ADDR_W, 16, memory address width.
- LOAD_LEN, 65536, bytes received into memory per load phase (1..2^ADDR_W).
- DUMP_LEN, 65536, bytes transmitted from memory per dump phase (1..2^ADDR_W).

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE, begins a load phase.
- rx_ready  in  1  one-cycle strobe from receiver, byte valid.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  byte to transmit.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data; registered, 1-cycle latency.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- cpu_run  out  1  high while the core owns memory.
- cpu_done  in  1  level from core, run finished.
- cpu_addr  in  ADDR_W  core address.
- cpu_din  in  8  core write data.
- cpu_write  in  1  core write enable.
- cpu_read  in  1  core read enable.
- cpu_rdata  out  8  read data to core.
- count  out  ADDR_W+1  bytes completed in the current phase.
- phase  out  3  current state encoding.
- done  out  1  high in DONE.

Behaviour:
- States and encodings: IDLE=0, LOAD=1, RUN=2, DUMP_RD=3, DUMP_TX=4, DUMP_WAIT=5, DONE=6.
- Reset (any state, mid-phase included), next edge:
  - state=IDLE, count=0.
  - tx_start=0, mem_write=0, mem_read=0, cpu_run=0, done=0.
  - mem_addr=0, mem_din=0, tx_data=0.
  - Partial load/dump is abandoned; memory contents are untouched.
- IDLE:
  - Memory port idle.
  - start=1 → LOAD, count=0.
- LOAD, on each rx_ready:
  - mem_write=1 for exactly that cycle, with mem_addr=count[ADDR_W-1:0] and mem_din=rx_data (registered, 1 cycle after strobe).
  - count increments.
  - When the increment makes count==LOAD_LEN → RUN, count=0.
  - rx_ready in any other state is ignored; no write occurs.
- RUN:
  - cpu_run=1.
  - mem_addr, mem_din, mem_write and mem_read mirror the cpu_* inputs combinationally.
  - cpu_rdata=mem_dout.
  - cpu_done=1 → DUMP_RD, count=0, cpu_run drops the next cycle.
  - Outside RUN: cpu_write and cpu_read are blocked and cpu_rdata=0.
- DUMP_RD:
  - mem_read=1, mem_addr=count[ADDR_W-1:0] for one cycle → DUMP_TX.
- DUMP_TX:
  - Waits until tx_busy=0.
  - Then latches tx_data=mem_dout and pulses tx_start for 1 cycle → DUMP_WAIT.
- DUMP_WAIT:
  - Waits for tx_busy to rise, then fall.
  - If tx_busy never rises within 2 cycles of tx_start, the byte is treated as sent; this covers transmitters that drop busy immediately.
  - On completion, count increments.
  - count==DUMP_LEN → DONE; otherwise → DUMP_RD.
- DONE:
  - done=1.
  - Holds until start=0, then → IDLE. A held start never retriggers.
- Width and wrap rules:
  - count is ADDR_W+1 bits so the value 2^ADDR_W is representable.
  - Addresses never wrap within a phase.
- Simultaneous events:
  - Reset beats everything.
  - start in states other than IDLE/DONE is ignored.
  - rx_ready coincident with the LOAD→RUN transition cycle is the final byte; a strobe after that is dropped.
- Latency:
  - Load: 1 cycle per byte.
  - Dump: read→tx_start is 2 cycles minimum when tx_busy=0.

Test Plan:
- Load (LOAD_LEN=4, DUMP_LEN=4): start=1, rx_ready strobes with 0xA1,0xB2,0xC3,0xD4 spaced by idle cycles → four mem_write pulses at addr 0..3 with those data; phase=RUN after the 4th; count sequence 1,2,3,4→0.
- RUN arbitration: core writes 0x5A to addr 2 then reads it, then cpu_done=1 → mem_write mirrors cpu_write; cpu_rdata=0x5A one cycle after read; cpu_run=0 the cycle after DUMP_RD is entered. cpu_write=1 in IDLE → mem_write stays 0.
- Dump: transmitter model busy for 10 cycles per byte → tx_start pulses exactly 4 times; tx_data=0xA1,0xB2,0x5A,0xD4; each pulse only when tx_busy=0; done=1 after the 4th busy falls.
- Stray/edge input: rx_ready strobes during RUN and DUMP → no mem_write. start held high through DONE → stays DONE until start=0, then IDLE.
- Reset mid-phase: Reset=1 after 2 bytes of LOAD, and separately during DUMP_WAIT → next edge phase=0, count=0, tx_start=0, mem_write=0; a new start performs a full load from address 0.
- Max size (ADDR_W=4, LOAD_LEN=16): 16 rx bytes → final write at addr 15, count reaches 16 without wrap, transition to RUN.
